// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Brief    : Shared types and constants for the turn-command path.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE   = 2'd0,
        TMR_ARMED  = 2'd1,
        TMR_REPEAT = 2'd2
    } tmr_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/repeat_timer.sv
`default_nettype none
// ============================================================================
// Module   : repeat_timer
// Brief    : Per-button hold timer producing auto-repeat ticks.
// Revision : 1.0 - initial release
// ============================================================================
module repeat_timer
    import snake_pkg::*;
#(
    parameter int INIT_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD = 6_250_000,
    parameter int CNT_W         = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic btn,
    input  logic press,
    output logic tick
);

    localparam logic [CNT_W-1:0] INIT_LOAD   = CNT_W'(INIT_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    tmr_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Tick is decoded from the expiry cycle so the press and repeat paths share the same latency.
    assign tick = enable && btn && (state != TMR_IDLE) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TMR_IDLE;
            cnt   <= '0;
        end else if (!enable || !btn) begin
            state <= TMR_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                TMR_IDLE: begin
                    if (press) begin
                        state <= TMR_ARMED;
                        cnt   <= INIT_LOAD;
                    end
                end
                TMR_ARMED, TMR_REPEAT: begin
                    if (cnt == '0) begin
                        state <= TMR_REPEAT;
                        cnt   <= REPEAT_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= TMR_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/turn_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : turn_cmd_arbiter
// Brief    : Two-button turn command arbiter with auto-repeat and handshake.
// Revision : 1.0 - initial release
// ============================================================================
module turn_cmd_arbiter
    import snake_pkg::*;
#(
    parameter int INIT_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD = 6_250_000,
    parameter int CNT_W         = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn0,
    input  logic btn1,
    input  logic enable,
    output logic cmd_valid,
    output logic cmd_dir,
    input  logic cmd_ready,
    output logic overrun
);

    logic [1:0] btn;
    logic [1:0] btn_q;
    logic [1:0] press;
    logic [1:0] tick;
    logic [1:0] set_evt;
    logic [1:0] pending;
    logic [1:0] grant;
    logic       grant_dir;
    logic       last_grant;
    logic       slot_free;

    assign btn   = {btn1, btn0};
    assign press = btn & ~btn_q;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_timer
            repeat_timer #(
                .INIT_DELAY    (INIT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD),
                .CNT_W         (CNT_W)
            ) u_timer (
                .clk    (clk),
                .rst_n  (rst_n),
                .enable (enable),
                .btn    (btn[i]),
                .press  (press[i]),
                .tick   (tick[i])
            );
        end
    endgenerate

    assign set_evt   = (press | tick) & {2{enable}};
    assign slot_free = !cmd_valid || cmd_ready;

    // last_grant holds the direction of the previous grant; a tie goes to the other one.
    always_comb begin
        grant     = 2'b00;
        grant_dir = DIR_LEFT;
        if (enable && slot_free) begin
            case (pending)
                2'b01: begin
                    grant     = 2'b01;
                    grant_dir = DIR_LEFT;
                end
                2'b10: begin
                    grant     = 2'b10;
                    grant_dir = DIR_RIGHT;
                end
                2'b11: begin
                    if (last_grant == DIR_RIGHT) begin
                        grant     = 2'b01;
                        grant_dir = DIR_LEFT;
                    end else begin
                        grant     = 2'b10;
                        grant_dir = DIR_RIGHT;
                    end
                end
                default: begin
                    grant     = 2'b00;
                    grant_dir = DIR_LEFT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q      <= 2'b00;
            pending    <= 2'b00;
            last_grant <= DIR_RIGHT;
            cmd_valid  <= 1'b0;
            cmd_dir    <= DIR_LEFT;
            overrun    <= 1'b0;
        end else begin
            btn_q   <= btn;
            overrun <= |(set_evt & pending & ~grant);
            pending <= enable ? ((pending & ~grant) | set_evt) : 2'b00;
            if (|grant) begin
                cmd_valid  <= 1'b1;
                cmd_dir    <= grant_dir;
                last_grant <= grant_dir;
            end else if (cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
